// File: rtl/regfile_pkg.sv
// Shared definitions for the multiport register file: state encoding,
// default widths and a packed-bus slice helper.
package regfile_pkg;

    typedef enum logic [0:0] {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_e;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;

    // Widest bus and slice that rf_slice handles (4 ports x 64 bits).
    localparam int RF_BUS_MAX   = 256;
    localparam int RF_SLICE_MAX = 64;

    // Returns field idx of width w from a packed bus, zero-extended.
    function automatic logic [RF_SLICE_MAX-1:0] rf_slice(
        input logic [RF_BUS_MAX-1:0] bus,
        input int                    idx,
        input int                    w
    );
        logic [RF_SLICE_MAX-1:0] mask;
        mask = (RF_SLICE_MAX'(1) << w) - RF_SLICE_MAX'(1);
        return RF_SLICE_MAX'(bus >> (idx * w)) & mask;
    endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear-sweep controller: after reset it walks every entry once, issuing a
// zero write per cycle, then parks in READY until the next reset.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RF_CLEAR | sweep running, one entry cleared per cycle, busy high
// RF_READY | array fully cleared, user writes and reads allowed
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    output logic              o_busy,
    output logic              o_ready,
    output logic              o_sweep_we,
    output logic [ADDR_W-1:0] o_sweep_addr
);

    // One extra bit so the last index is compared without wrapping to 0.
    localparam logic [ADDR_W:0] LAST_IDX = {1'b0, {ADDR_W{1'b1}}};

    rf_state_e       r_state;
    logic [ADDR_W:0] r_count;
    logic            r_busy;

    // State, sweep counter and busy flag; reset restarts a full sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RF_CLEAR;
            r_count <= '0;
            r_busy  <= 1'b1;
        end else begin
            case (r_state)
                RF_CLEAR: begin
                    r_count <= r_count + 1'b1;
                    if (r_count == LAST_IDX) begin
                        r_state <= RF_READY;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= RF_READY;
                end
            endcase
        end
    end

    assign o_busy       = r_busy;
    assign o_ready      = (r_state == RF_READY);
    assign o_sweep_we   = (r_state == RF_CLEAR) && !rst;
    assign o_sweep_addr = r_count[ADDR_W-1:0];

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised multiport register file for the ID stage.
// Optional same-cycle write-to-read forwarding: define REGFILE_BYPASS_EN.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     regWrite,
    input  logic [ADDR_W-1:0]        writeReg,
    input  logic [DATA_W-1:0]        writeData,
    input  logic [NUM_RD*ADDR_W-1:0] readAddr,
    output logic [NUM_RD*DATA_W-1:0] readData,
    output logic                     busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_busy;
    logic              w_ready;
    logic              w_sweep_we;
    logic [ADDR_W-1:0] w_sweep_addr;
    logic              w_user_we;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;

    regfile_clear_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clear_fsm (
        .clk          (clk),
        .rst          (rst),
        .o_busy       (w_busy),
        .o_ready      (w_ready),
        .o_sweep_we   (w_sweep_we),
        .o_sweep_addr (w_sweep_addr)
    );

    // User write only lands in READY; entry 0 is protected when hardwired.
    assign w_user_we = w_ready && !rst && regWrite &&
                       !((ZERO_REG != 0) && (writeReg == '0));

    // Sweep clear has priority over the user port (they never overlap anyway).
    always_comb begin
        w_we    = 1'b0;
        w_waddr = writeReg;
        w_wdata = writeData;
        if (w_sweep_we) begin
            w_we    = 1'b1;
            w_waddr = w_sweep_addr;
            w_wdata = '0;
        end else if (w_user_we) begin
            w_we    = 1'b1;
        end
    end

    // Storage array; no reset, contents come from the sweep.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    genvar k;
    generate
        for (k = 0; k < NUM_RD; k++) begin : g_rd
            logic [ADDR_W-1:0] w_raddr;
            logic [DATA_W-1:0] w_rdata;

            assign w_raddr = ADDR_W'(rf_slice(RF_BUS_MAX'(readAddr), k, ADDR_W));

            // Asynchronous read with optional forwarding, zero-reg and busy masking.
            always_comb begin
                w_rdata = r_mem[w_raddr];
`ifdef REGFILE_BYPASS_EN
                if (w_user_we && (writeReg == w_raddr)) begin
                    w_rdata = writeData;
                end
`else
`endif
                if ((ZERO_REG != 0) && (w_raddr == '0)) begin
                    w_rdata = '0;
                end
                if (w_busy) begin
                    w_rdata = '0;
                end
            end

            assign readData[k*DATA_W +: DATA_W] = w_rdata;
        end
    endgenerate

    assign busy = w_busy;

endmodule

// File: tb/tb_regfile_multiport.sv
// Self-checking bench for regfile_multiport. Two instances share the write
// port: dut_a (4 read ports, zero register on) and dut_b (2 ports, zero
// register off). A behavioural model tracks sweep progress and contents.
module tb_regfile_multiport;

    logic        clk;
    logic        rst;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [19:0] rd_addr_a;
    logic [127:0] rd_data_a;
    logic        busy_a;
    logic [9:0]  rd_addr_b;
    logic [63:0] rd_data_b;
    logic        busy_b;

    int n_checks;
    int n_fail;

    regfile_multiport #(
        .DATA_W   (32),
        .ADDR_W   (5),
        .NUM_RD   (4),
        .ZERO_REG (1)
    ) dut_a (
        .clk       (clk),
        .rst       (rst),
        .regWrite  (reg_write),
        .writeReg  (write_reg),
        .writeData (write_data),
        .readAddr  (rd_addr_a),
        .readData  (rd_data_a),
        .busy      (busy_a)
    );

    regfile_multiport #(
        .DATA_W   (32),
        .ADDR_W   (5),
        .NUM_RD   (2),
        .ZERO_REG (0)
    ) dut_b (
        .clk       (clk),
        .rst       (rst),
        .regWrite  (reg_write),
        .writeReg  (write_reg),
        .writeData (write_data),
        .readAddr  (rd_addr_b),
        .readData  (rd_data_b),
        .busy      (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: contents only become known once a whole sweep of
    // 32 uninterrupted non-reset edges has happened.
    logic [31:0] m_a [32];
    logic [31:0] m_b [32];
    int          m_left;

    function automatic void model_edge();
        if (rst) begin
            m_left = 32;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                for (int i = 0; i < 32; i++) begin
                    m_a[i] = 32'h0;
                    m_b[i] = 32'h0;
                end
            end
        end else if (reg_write) begin
            if (write_reg != 5'd0) m_a[write_reg] = write_data;
            m_b[write_reg] = write_data;
        end
    endfunction

    function automatic logic m_busy();
        return (m_left > 0);
    endfunction

    function automatic logic [31:0] exp_a(input logic [4:0] a);
        if (m_left > 0) return 32'h0;
        if (a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (reg_write && !rst && a == write_reg) return write_data;
`endif
        return m_a[a];
    endfunction

    function automatic logic [31:0] exp_b(input logic [4:0] a);
        if (m_left > 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (reg_write && !rst && a == write_reg) return write_data;
`endif
        return m_b[a];
    endfunction

    // Advance one clock: model sees the same inputs as the DUT edge.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int busy_cnt;
        int guard;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        n_checks++;
        if (busy_a !== 1'b1 || busy_b !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_busy got a=%b b=%b exp=1", busy_a, busy_b);
        end
        busy_cnt = 1;
        guard = 0;
        // Write to reg 5 during the sweep; it must be dropped.
        reg_write  = 1'b1;
        write_reg  = 5'd5;
        write_data = 32'h1234;
        while (busy_a === 1'b1 && guard < 100) begin
            rd_addr_a = $urandom;
            #1;
            n_checks++;
            if (rd_data_a !== 128'h0) begin
                n_fail++;
                $display("FAIL sweep_read_zero got=%h exp=0", rd_data_a);
            end
            step();
            guard++;
            n_checks++;
            if (busy_a !== m_busy() || busy_b !== m_busy()) begin
                n_fail++;
                $display("FAIL sweep_busy cycle=%0d got a=%b b=%b exp=%b", guard, busy_a, busy_b, m_busy());
            end
            if (busy_a === 1'b1) busy_cnt++;
        end
        reg_write = 1'b0;
        n_checks++;
        if (busy_cnt != 32) begin
            n_fail++;
            $display("FAIL sweep_length got=%0d exp=32", busy_cnt);
        end
        for (int a = 0; a < 32; a++) begin
            for (int k = 0; k < 4; k++) rd_addr_a[k*5 +: 5] = 5'(a);
            for (int k = 0; k < 2; k++) rd_addr_b[k*5 +: 5] = 5'(a);
            #1;
            n_checks++;
            if (rd_data_a !== 128'h0 || rd_data_b !== 64'h0) begin
                n_fail++;
                $display("FAIL cleared_entry addr=%0d got a=%h b=%h exp=0", a, rd_data_a, rd_data_b);
            end
        end
    endtask

    task automatic test_write_read();
        logic [31:0] exp_wc;
        reg_write  = 1'b1;
        write_reg  = 5'd2;
        write_data = 32'h0000_0007;
        rd_addr_a  = {5'd2, 5'd2, 5'd2, 5'd2};
        rd_addr_b  = {5'd2, 5'd2};
        #1;
        exp_wc = exp_a(5'd2);
        n_checks++;
        if (rd_data_a[31:0] !== exp_wc || rd_data_b[31:0] !== exp_b(5'd2)) begin
            n_fail++;
            $display("FAIL write_cycle_read got a=%h b=%h exp=%h", rd_data_a[31:0], rd_data_b[31:0], exp_wc);
        end
        step();
        reg_write = 1'b0;
        #1;
        n_checks++;
        if (rd_data_a[31:0] !== 32'h7 || rd_data_b[31:0] !== 32'h7) begin
            n_fail++;
            $display("FAIL write_next_read got a=%h b=%h exp=7", rd_data_a[31:0], rd_data_b[31:0]);
        end
    endtask

    task automatic test_zero_reg();
        reg_write  = 1'b1;
        write_reg  = 5'd0;
        write_data = 32'hDEAD_BEEF;
        rd_addr_a  = 20'h0;
        rd_addr_b  = 10'h0;
        #1;
        n_checks++;
        if (rd_data_a !== 128'h0 || rd_data_b[31:0] !== exp_b(5'd0)) begin
            n_fail++;
            $display("FAIL zero_write_cycle got a=%h b=%h exp_b=%h", rd_data_a, rd_data_b[31:0], exp_b(5'd0));
        end
        step();
        reg_write = 1'b0;
        #1;
        n_checks++;
        if (rd_data_a !== 128'h0) begin
            n_fail++;
            $display("FAIL zero_reg_a got=%h exp=0", rd_data_a);
        end
        n_checks++;
        if (rd_data_b !== {2{32'hDEAD_BEEF}}) begin
            n_fail++;
            $display("FAIL zero_reg_off_b got=%h exp=%h", rd_data_b, {2{32'hDEAD_BEEF}});
        end
    endtask

    task automatic test_multiport();
        logic [31:0] vals [4];
        vals = '{32'd4, 32'd7, 32'd1, 32'd1};
        for (int i = 0; i < 4; i++) begin
            reg_write  = 1'b1;
            write_reg  = 5'(i + 1);
            write_data = vals[i];
            step();
        end
        reg_write = 1'b0;
        rd_addr_a = {5'd4, 5'd3, 5'd2, 5'd1};
        #1;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (rd_data_a[k*32 +: 32] !== vals[k]) begin
                n_fail++;
                $display("FAIL multiport port%0d got=%h exp=%h", k, rd_data_a[k*32 +: 32], vals[k]);
            end
        end
        rd_addr_a = {4{5'd2}};
        #1;
        n_checks++;
        if (rd_data_a !== {4{32'd7}}) begin
            n_fail++;
            $display("FAIL same_addr_ports got=%h exp=%h", rd_data_a, {4{32'd7}});
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 300; c++) begin
            reg_write  = ($urandom_range(0, 3) != 0);
            write_reg  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            write_data = $urandom;
            for (int k = 0; k < 4; k++)
                rd_addr_a[k*5 +: 5] = ($urandom_range(0, 2) == 0) ? write_reg : 5'($urandom_range(0, 7));
            for (int k = 0; k < 2; k++)
                rd_addr_b[k*5 +: 5] = ($urandom_range(0, 2) == 0) ? write_reg : 5'($urandom_range(0, 7));
            #1;
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (rd_data_a[k*32 +: 32] !== exp_a(rd_addr_a[k*5 +: 5])) begin
                    n_fail++;
                    $display("FAIL rand_a cyc=%0d port%0d addr=%0d got=%h exp=%h", c, k,
                             rd_addr_a[k*5 +: 5], rd_data_a[k*32 +: 32], exp_a(rd_addr_a[k*5 +: 5]));
                end
            end
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (rd_data_b[k*32 +: 32] !== exp_b(rd_addr_b[k*5 +: 5])) begin
                    n_fail++;
                    $display("FAIL rand_b cyc=%0d port%0d addr=%0d got=%h exp=%h", c, k,
                             rd_addr_b[k*5 +: 5], rd_data_b[k*32 +: 32], exp_b(rd_addr_b[k*5 +: 5]));
                end
            end
            step();
        end
        reg_write = 1'b0;
    endtask

    task automatic test_reset_midsweep();
        int busy_cnt;
        int guard;
        rst = 1'b1;
        step();
        rst = 1'b0;
        busy_cnt = (busy_a === 1'b1) ? 1 : 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (busy_a === 1'b1) busy_cnt++;
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        if (busy_a === 1'b1) busy_cnt++;
        guard = 0;
        while (busy_a === 1'b1 && guard < 100) begin
            rd_addr_a = $urandom;
            #1;
            n_checks++;
            if (rd_data_a !== 128'h0) begin
                n_fail++;
                $display("FAIL midsweep_read_zero got=%h exp=0", rd_data_a);
            end
            step();
            guard++;
            n_checks++;
            if (busy_a !== m_busy()) begin
                n_fail++;
                $display("FAIL midsweep_busy got=%b exp=%b", busy_a, m_busy());
            end
            if (busy_a === 1'b1) busy_cnt++;
        end
        n_checks++;
        if (busy_cnt != 10 + 1 + 32) begin
            n_fail++;
            $display("FAIL midsweep_length got=%0d exp=%0d", busy_cnt, 10 + 1 + 32);
        end
        for (int a = 0; a < 32; a++) begin
            for (int k = 0; k < 2; k++) rd_addr_b[k*5 +: 5] = 5'(a);
            rd_addr_a = {4{5'(a)}};
            #1;
            n_checks++;
            if (rd_data_a !== 128'h0 || rd_data_b !== 64'h0) begin
                n_fail++;
                $display("FAIL resweep_entry addr=%0d got a=%h b=%h exp=0", a, rd_data_a, rd_data_b);
            end
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        m_left     = 0;
        rst        = 1'b1;
        reg_write  = 1'b0;
        write_reg  = 5'd0;
        write_data = 32'h0;
        rd_addr_a  = 20'h0;
        rd_addr_b  = 10'h0;
        test_reset();
        test_write_read();
        test_zero_reg();
        test_multiport();
        test_back_to_back();
        test_reset_midsweep();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
